// File: rtl/csr_timer_pkg.sv
// Shared definitions for the LoongArch timer CSR block.
// Holds CSR addresses, TCFG field positions and timer state encoding.
package csr_timer_pkg;

    localparam logic [13:0] CSR_TID   = 14'h40;
    localparam logic [13:0] CSR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_TICLR = 14'h44;

    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;

    typedef enum logic [1:0] {
        TMR_IDLE    = 2'd0,
        TMR_COUNT   = 2'd1,
        TMR_EXPIRED = 2'd2
    } timer_state_t;

endpackage

// File: rtl/csr_stable_counter.sv
// Free-running 64-bit stable counter feeding rdcnt{vl,vh}.w.
// Ports: clk, rst (async active-low), cnt (64-bit count). Built only with TIMER_CNT64_EN.
`ifdef TIMER_CNT64_EN
module csr_stable_counter (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 64'h0;
        end else begin
            cnt <= cnt + 64'h1;
        end
    end

endmodule
`endif

// File: rtl/csr_timer.sv
// Timer CSRs TID/TCFG/TVAL/TICLR and timer interrupt source for the CSR file.
// Ports: clk, rst (async active-low), CSR read/write port, is_ti, cnt_value. Macro: TIMER_CNT64_EN.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter int          TIMER_WIDTH = 32,
    parameter logic [31:0] TID_RESET   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic [13:0] read_addr,
    output logic [31:0] read_data,
    input  logic        write_en,
    input  logic [13:0] write_addr,
    input  logic [31:0] write_data,
    output logic        is_ti,
    output logic [63:0] cnt_value
);

    localparam int N = TIMER_WIDTH;

    timer_state_t   state;
    logic [31:0]    tid;
    logic [N-1:0]   tcfg;
    logic [N-1:0]   tval;

    logic           tid_we;
    logic           tcfg_we;
    logic           ticlr_we;
    logic           expire;
    logic [N-1:0]   load_wr;
    logic [N-1:0]   load_cfg;
    logic [31:0]    tcfg_ext;
    logic [31:0]    tval_ext;
    logic [31:0]    rd_mux;

    assign tid_we   = write_en && (write_addr == CSR_TID);
    assign tcfg_we  = write_en && (write_addr == CSR_TCFG);
    assign ticlr_we = write_en && (write_addr == CSR_TICLR);

    assign load_wr  = {write_data[N-1:TCFG_INITVAL_LSB], 2'b00};
    assign load_cfg = {tcfg[N-1:TCFG_INITVAL_LSB], 2'b00};

    // A TCFG write in the same cycle overrides any expiry.
    assign expire = (state == TMR_COUNT) && (tval == '0) && !tcfg_we;

    always_comb begin
        tcfg_ext = 32'h0;
        tval_ext = 32'h0;
        tcfg_ext[N-1:0] = tcfg;
        tval_ext[N-1:0] = tval;
    end

    always_comb begin
        rd_mux = 32'h0;
        unique case (1'b1)
            (read_addr == CSR_TID):  rd_mux = tid;
            (read_addr == CSR_TCFG): rd_mux = tcfg_ext;
            (read_addr == CSR_TVAL): rd_mux = tval_ext;
            default:                 rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= TMR_IDLE;
            tid       <= TID_RESET;
            tcfg      <= '0;
            tval      <= '0;
            is_ti     <= 1'b0;
            read_data <= 32'h0;
        end else begin
            if (tid_we) begin
                tid <= write_data;
            end

            if (tcfg_we) begin
                tcfg  <= write_data[N-1:0];
                tval  <= load_wr;
                state <= write_data[TCFG_EN] ? TMR_COUNT : TMR_IDLE;
            end else begin
                unique case (state)
                    TMR_COUNT: begin
                        if (tval != '0) begin
                            tval <= tval - 1'b1;
                        end else if (tcfg[TCFG_PERIODIC]) begin
                            tval <= load_cfg;
                        end else begin
                            state <= TMR_EXPIRED;
                        end
                    end
                    default: ;
                endcase
            end

            // A new expiry beats a simultaneous clear so no event is lost.
            if (expire) begin
                is_ti <= 1'b1;
            end else if (ticlr_we && write_data[0]) begin
                is_ti <= 1'b0;
            end

            read_data <= read_en ? rd_mux : 32'h0;
        end
    end

`ifdef TIMER_CNT64_EN
    csr_stable_counter u_cnt (
        .clk (clk),
        .rst (rst),
        .cnt (cnt_value)
    );
`else
    assign cnt_value = 64'h0;
`endif

endmodule

// File: tb/tb_csr_timer.sv
// Randomized self-checking bench for csr_timer against an elapsed-time model.
// Build with or without TIMER_CNT64_EN.
module tb_csr_timer;
    import csr_timer_pkg::*;

    logic        clk;
    logic        rst;
    logic        read_en;
    logic [13:0] read_addr;
    logic [31:0] read_data;
    logic        write_en;
    logic [13:0] write_addr;
    logic [31:0] write_data;
    logic        is_ti;
    logic [63:0] cnt_value;

    int checks = 0;
    int errors = 0;

    csr_timer #(
        .TIMER_WIDTH (32),
        .TID_RESET   (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .is_ti      (is_ti),
        .cnt_value  (cnt_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: timer described by load value and edges elapsed since last TCFG write.
    logic [31:0] m_tid;
    logic [31:0] m_tcfg;
    longint      m_load;
    logic        m_en;
    logic        m_per;
    longint      m_d;
    logic        m_ti;
    longint      m_cnt;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_tval();
        if (!m_en) return 32'(m_load);
        if (m_per) return 32'(m_load - (m_d % (m_load + 1)));
        return (m_d <= m_load) ? 32'(m_load - m_d) : 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        if (a == CSR_TID)  return m_tid;
        if (a == CSR_TCFG) return m_tcfg;
        if (a == CSR_TVAL) return m_tval();
        return 32'h0;
    endfunction

    function automatic logic [63:0] cnt_exp();
`ifdef TIMER_CNT64_EN
        return 64'(m_cnt);
`else
        return 64'h0;
`endif
    endfunction

    task automatic m_reset();
        m_tid  = 32'h0;
        m_tcfg = 32'h0;
        m_load = 0;
        m_en   = 1'b0;
        m_per  = 1'b0;
        m_d    = 0;
        m_ti   = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic cyc(input logic ren, input logic [13:0] ra,
                       input logic wen, input logic [13:0] wa,
                       input logic [31:0] wd);
        logic [31:0] rexp;
        logic        fire;
        read_en    = ren;
        read_addr  = ra;
        write_en   = wen;
        write_addr = wa;
        write_data = wd;
        rexp = ren ? m_read(ra) : 32'h0;
        @(posedge clk);
        #1;
        fire = 1'b0;
        if (wen && wa == CSR_TCFG) begin
            m_tcfg = wd;
            m_load = longint'(wd & 32'hFFFF_FFFC);
            m_en   = wd[0];
            m_per  = wd[1];
            m_d    = 0;
        end else begin
            m_d++;
            if (m_en)
                fire = m_per ? ((m_d % (m_load + 1)) == 0)
                             : (m_d == m_load + 1);
        end
        if (wen && wa == CSR_TID) m_tid = wd;
        if (fire) m_ti = 1'b1;
        else if (wen && wa == CSR_TICLR && wd[0]) m_ti = 1'b0;
        m_cnt++;
        chk("read_data", 64'(read_data), 64'(rexp));
        chk("is_ti", 64'(is_ti), 64'(m_ti));
        chk("cnt_value", cnt_value, cnt_exp());
        read_en  = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a);
        cyc(1'b1, a, 1'b0, 14'h0, 32'h0);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        cyc(1'b0, 14'h0, 1'b1, a, d);
    endtask

    initial begin
        int since;
        int rise_at;
        int rises;
        logic prev;
        logic [13:0] ra;
        logic [13:0] wa;
        logic [31:0] wd;

        rst = 1'b0;
        read_en = 1'b0;
        read_addr = 14'h0;
        write_en = 1'b0;
        write_addr = 14'h0;
        write_data = 32'h0;
        m_reset();
        #2;
        chk("rst_read_data", 64'(read_data), 64'h0);
        chk("rst_is_ti", 64'(is_ti), 64'h0);
        chk("rst_cnt", cnt_value, 64'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;

        // One-shot, InitVal=4
        wr(CSR_TCFG, 32'h0000_0011);
        since = 0;
        rd(CSR_TVAL);
        since++;
        chk("oneshot_tval16", 64'(read_data), 64'd16);
        rise_at = -1;
        rises = 0;
        prev = is_ti;
        for (int i = 0; i < 30; i++) begin
            rd(CSR_TVAL);
            since++;
            if (is_ti && !prev) begin
                rises++;
                rise_at = since;
            end
            prev = is_ti;
        end
        chk("oneshot_rises", 64'(rises), 64'd1);
        chk("oneshot_rise_at", 64'(rise_at), 64'd17);
        rd(CSR_TVAL);
        chk("oneshot_tval0", 64'(read_data), 64'd0);
        wr(CSR_TICLR, 32'h1);
        chk("oneshot_clr", 64'(is_ti), 64'd0);
        for (int i = 0; i < 20; i++) rd(CSR_TVAL);
        chk("oneshot_no_refire", 64'(is_ti), 64'd0);

        // Periodic, InitVal=2: clear mid-period and on an expiry edge
        wr(CSR_TCFG, 32'h0000_000B);
        for (int i = 1; i <= 36; i++) begin
            cyc(1'b1, CSR_TVAL, (i % 9 == 4) || (i == 18), CSR_TICLR, 32'h1);
            if (i % 9 == 0) chk("per_ti_set", 64'(is_ti), 64'd1);
            if (i % 9 == 5) chk("per_ti_clr", 64'(is_ti), 64'd0);
        end
        wr(CSR_TICLR, 32'h1);

        // Collision: TCFG write on the expiry edge
        wr(CSR_TCFG, 32'h0000_0005);
        for (int i = 0; i < 4; i++) rd(CSR_TVAL);
        wr(CSR_TCFG, 32'h0000_0020);
        chk("coll_no_ti", 64'(is_ti), 64'd0);
        rd(CSR_TVAL);
        chk("coll_tval", 64'(read_data), 64'h20);
        for (int i = 0; i < 5; i++) rd(CSR_TVAL);
        chk("coll_idle_tval", 64'(read_data), 64'h20);

        // Disable mid-count at TVAL=5
        wr(CSR_TCFG, 32'h0000_0011);
        for (int i = 0; i < 11; i++) rd(CSR_TVAL);
        wr(CSR_TCFG, 32'h0);
        rd(CSR_TCFG);
        chk("dis_tcfg", 64'(read_data), 64'h0);
        for (int i = 0; i < 20; i++) rd(CSR_TVAL);
        chk("dis_tval", 64'(read_data), 64'h0);
        chk("dis_no_ti", 64'(is_ti), 64'd0);

        // Reads: unmapped, TVAL write ignored, TID readback
        wr(CSR_TID, 32'hDEAD_BEEF);
        rd(CSR_TID);
        chk("tid_rb", 64'(read_data), 64'hDEAD_BEEF);
        rd(14'h43);
        chk("unmapped", 64'(read_data), 64'h0);
        wr(CSR_TVAL, 32'h1234_5678);
        rd(CSR_TVAL);
        chk("tval_ro", 64'(read_data), 64'h0);
        rd(CSR_TICLR);
        chk("ticlr_rd", 64'(read_data), 64'h0);

        // Async reset mid-count
        wr(CSR_TCFG, 32'h0000_0043);
        for (int i = 0; i < 10; i++) rd(CSR_TID);
        #3;
        rst = 1'b0;
        #1;
        m_reset();
        chk("arst_read_data", 64'(read_data), 64'h0);
        chk("arst_is_ti", 64'(is_ti), 64'h0);
        chk("arst_cnt", cnt_value, 64'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_cnt", cnt_value, 64'h0);
        rst = 1'b1;
        rd(CSR_TID);
        chk("arst_tid", 64'(read_data), 64'h0);
        rd(CSR_TVAL);
        chk("arst_tval", 64'(read_data), 64'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: ra = CSR_TID;
                1: ra = CSR_TCFG;
                2, 3: ra = CSR_TVAL;
                4: ra = CSR_TICLR;
                default: ra = 14'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: wa = CSR_TID;
                1: wa = CSR_TCFG;
                2: wa = CSR_TVAL;
                3: wa = CSR_TICLR;
                default: wa = 14'h43;
            endcase
            wd = $urandom;
            if (wa == CSR_TCFG)
                wd = {$urandom_range(0, 63) > 60 ? wd[31:8] : 24'h0,
                      wd[7:0] & 8'h1F};
            cyc(1'($urandom), ra, $urandom_range(0, 7) == 0, wa, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
